i2c_slave_read_responder: RTL
=============================

// Module: i2c_slave_read_responder
// PURPOSE
// - Synthesizable I2C slave, bus-side counterpart of our read master: detects START/STOP,
//   matches a 7-bit address, ACKs read requests, and shifts out data bytes from a local
//   producer via a valid/ready handshake. SCL/SDA are oversampled on the system clock.
// - Read-only: write requests (R/W=0) are NACKed. Open-drain: *_oe=1 pulls the line low.
// PARAMETERS
// - SLAVE_ADDR     7'h50  7-bit address this slave answers to
// - SYNC_STAGES    2      synchronizer flops on scl_in/sda_in (>=2)
// - UNDERRUN_BYTE  8'hFF  byte sent when tx_valid is low at load time (no-stretch build)
// PORTS
// - clk        in   1  system clock, >=10x SCL rate
// - rst        in   1  reset, asynchronous, active-high
// - scl_in     in   1  sampled SCL bus level
// - sda_in     in   1  sampled SDA bus level
// - sda_oe     out  1  1 = pull SDA low
// - scl_oe     out  1  1 = hold SCL low (clock stretch); constant 0 without CLK_STRETCH_EN
// - tx_data    in   8  next byte to transmit
// - tx_valid   in   1  tx_data valid
// - tx_ready   out  1  1-clk pulse: tx_data consumed this cycle
// - busy       out  1  1 from address match until STOP/repeated START/NACK
// - nack_seen  out  1  1-clk pulse: master NACKed a data byte
// - underrun   out  1  1-clk pulse: byte needed while tx_valid=0 (no-stretch build)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, shift/bit counters cleared. Async assert, sync release.
// - Edge detect on synchronized lines: scl_rise/scl_fall; START = sda fall with scl high;
//   STOP = sda rise with scl high. Event latency SYNC_STAGES+1 clk after pin change.
// - States: IDLE, ADDR, ADDR_ACK, TX_BYTE, MACK, WAIT_STOP.
// - IDLE: sda_oe=0. START -> ADDR, bit_cnt=0.
// - ADDR: shift sda on each scl_rise, MSB first; after 8th rise compare [7:1] to SLAVE_ADDR.
//   Match & R/W=1 -> ADDR_ACK; else -> WAIT_STOP (no ACK, sda_oe stays 0).
// - ADDR_ACK: on scl_fall after 8th bit assert sda_oe=1, busy=1. On next scl_fall (end of
//   ACK slot) load byte: tx_valid=1 -> shreg=tx_data, tx_ready pulse; else UNDERRUN_BYTE +
//   underrun pulse. Same cycle sda_oe=~shreg[7] -> TX_BYTE.
// - TX_BYTE: on each scl_fall shift left, sda_oe=~shreg[7]; after 8th bit's scl_fall sda_oe=0
//   -> MACK. Bit counter wraps 7->0 per byte.
// - MACK: sample sda at scl_rise. 0 (ACK) -> on following scl_fall load next byte exactly as
//   in ADDR_ACK -> TX_BYTE. 1 (NACK) -> nack_seen pulse, busy=0 -> WAIT_STOP.
// - WAIT_STOP: sda_oe=0; STOP -> IDLE; START -> ADDR.
// - STOP in any state -> IDLE, sda_oe=0, busy=0 within 1 clk of detection (abort mid-byte;
//   loaded byte is discarded, not re-offered). Repeated START in any state -> ADDR.
// - START/STOP take priority over scl edges in the same cycle.
// - tx_ready never pulses outside a load point; at most one pulse per byte.
// - sda_oe changes only on scl_fall or on STOP/START/rst (never while SCL high in a slot).
// CONFIGURATION
// - CLK_STRETCH_EN defined: at a load point with tx_valid=0, scl_oe=1 (hold SCL low), no
//   underrun; when tx_valid rises: load, tx_ready pulse, drive MSB, release scl_oe 1 clk later.
//   STOP/START/rst release scl_oe immediately.
// - CLK_STRETCH_EN undefined: scl_oe tied 0; underrun path sends UNDERRUN_BYTE.
// TESTING
// - Master read addr 0x50, tx_data=8'hA5, tx_valid=1 -> ACK low on 9th SCL, bus bits 10100101,
//   one tx_ready pulse, busy=1 until master NACK, nack_seen pulse, idle after STOP.
// - Read addr 0x51 -> sda_oe never asserts, busy=0, tx_ready never pulses.
// - Write to 0x50 (R/W=0) -> address NACK (SDA high on 9th clock), WAIT_STOP, then IDLE.
// - Two-byte read, tx_data 8'hA5 then 8'h3C, master ACK then NACK -> two tx_ready pulses,
//   bus bytes A5,3C, one nack_seen.
// - STOP injected after 3rd data bit -> sda_oe=0 within SYNC_STAGES+2 clk; rst mid-byte ->
//   all outputs 0 immediately; next transaction completes normally.
// - tx_valid=0 at load: no-stretch -> 8'hFF on bus + underrun pulse; CLK_STRETCH_EN -> scl_oe=1
//   until tx_valid raised 20 clk later, then byte sent correctly.

Source files
------------

// File: rtl/i2c_slave_read_responder_if.sv
// i2c_slave_read_responder_if
// Groups the I2C pin-side and producer-side signals of the read responder.
//   scl_in/sda_in   : sampled bus levels (driven toward the slave)
//   sda_oe/scl_oe   : open-drain pull-low enables (driven by the slave)
//   tx_data/tx_valid: byte producer toward the slave
//   tx_ready        : 1-clk consume pulse from the slave
//   busy/nack_seen/underrun : slave status
// Modports: slave (the responder), master (bus model / producer side).
interface i2c_slave_read_responder_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       scl_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       nack_seen;
  logic       underrun;

  modport slave (
    input  scl_in, sda_in, tx_data, tx_valid,
    output sda_oe, scl_oe, tx_ready, busy, nack_seen, underrun
  );

  modport master (
    output scl_in, sda_in, tx_data, tx_valid,
    input  sda_oe, scl_oe, tx_ready, busy, nack_seen, underrun
  );
endinterface

// File: rtl/i2c_slave_read_responder.sv
// i2c_slave_read_responder
// Read-only I2C slave: detects START/STOP on oversampled SCL/SDA, matches a
// 7-bit address, ACKs read requests and shifts out bytes from a valid/ready
// producer. Write requests are left un-ACKed.
// Ports:
//   clk  : system clock (>=10x SCL)
//   rst  : asynchronous active-high reset (released synchronously)
//   bus  : i2c_slave_read_responder_if.slave (pins, producer, status)
// Build option: define CLK_STRETCH_EN to hold SCL low when no byte is
// available at a load point; otherwise UNDERRUN_BYTE is sent instead.
module i2c_slave_read_responder #(
  parameter logic [6:0]  SLAVE_ADDR    = 7'h50,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic [7:0]  UNDERRUN_BYTE = 8'hFF
) (
  input logic                       clk,
  input logic                       rst,
  i2c_slave_read_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, TX_BYTE, MACK, WAIT_STOP} state_t;
  state_t state, state_next;

  // Reset: asserts immediately, releases on the clock.
  logic [1:0] rst_sync;
  logic       rst_int;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= '1;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;

  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic sda_oe_q, sda_oe_n, busy_q, busy_n, mack_ok, mack_ok_n;
  logic tx_ready_q, tx_ready_n, nack_q, nack_n, underrun_q, underrun_n;
  logic addr_hit, load_pt, do_load;

  // shreg doubles as the address shifter; the 8th bit is still on sda_s.
  assign addr_hit = ({shreg[6:0], sda_s} == {SLAVE_ADDR, 1'b1});
  // In ADDR_ACK, sda_oe=1 marks that the ACK is already on the bus, so the
  // next falling edge closes the ACK slot.
  assign load_pt  = scl_fall && ((state == ADDR_ACK && sda_oe_q) || (state == MACK && mack_ok));

`ifdef CLK_STRETCH_EN
  logic scl_oe_q, scl_oe_n, load_wait, load_wait_n;
  assign do_load = (load_pt | load_wait) & bus.tx_valid;
`else
  assign do_load = load_pt;
`endif

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      mack_ok    <= 1'b0;
      tx_ready_q <= 1'b0;
      nack_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef CLK_STRETCH_EN
      scl_oe_q   <= 1'b0;
      load_wait  <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      sda_oe_q   <= sda_oe_n;
      busy_q     <= busy_n;
      mack_ok    <= mack_ok_n;
      tx_ready_q <= tx_ready_n;
      nack_q     <= nack_n;
      underrun_q <= underrun_n;
`ifdef CLK_STRETCH_EN
      scl_oe_q   <= scl_oe_n;
      load_wait  <= load_wait_n;
`endif
    end
  end

  always_comb begin
    state_next = state;
    if (stop_c) state_next = IDLE;
    else if (start_c) state_next = ADDR;
    else begin
      case (state)
        ADDR:     if (scl_rise && bit_cnt == 3'd7) state_next = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (do_load) state_next = TX_BYTE;
        TX_BYTE:  if (scl_fall && bit_cnt == 3'd7) state_next = MACK;
        MACK: begin
          if (do_load) state_next = TX_BYTE;
          else if (scl_rise && !mack_ok && sda_s) state_next = WAIT_STOP;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    sda_oe_n   = sda_oe_q;
    busy_n     = busy_q;
    mack_ok_n  = mack_ok;
    tx_ready_n = 1'b0;
    nack_n     = 1'b0;
    underrun_n = 1'b0;
`ifdef CLK_STRETCH_EN
    scl_oe_n    = scl_oe_q;
    load_wait_n = load_wait;
`endif
    if (stop_c || start_c) begin
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      mack_ok_n = 1'b0;
`ifdef CLK_STRETCH_EN
      scl_oe_n    = 1'b0;
      load_wait_n = 1'b0;
`endif
    end else if (do_load) begin
`ifdef CLK_STRETCH_EN
      shreg_n     = bus.tx_data;
      tx_ready_n  = 1'b1;
      load_wait_n = 1'b0;
`else
      shreg_n    = bus.tx_valid ? bus.tx_data : UNDERRUN_BYTE;
      tx_ready_n = bus.tx_valid;
      underrun_n = ~bus.tx_valid;
`endif
      sda_oe_n  = ~shreg_n[7];
      bit_cnt_n = '0;
      mack_ok_n = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shreg_n   = {shreg[6:0], sda_s};
          bit_cnt_n = bit_cnt + 3'd1;
        end
        ADDR_ACK: if (scl_fall && !sda_oe_q) begin
          sda_oe_n = 1'b1;
          busy_n   = 1'b1;
        end
        TX_BYTE: begin
`ifdef CLK_STRETCH_EN
          scl_oe_n = 1'b0;
`endif
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
            end else begin
              shreg_n   = {shreg[6:0], 1'b0};
              sda_oe_n  = ~shreg[6];
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end
        MACK: if (scl_rise && !mack_ok) begin
          if (!sda_s) mack_ok_n = 1'b1;
          else begin
            nack_n = 1'b1;
            busy_n = 1'b0;
          end
        end
        default: ;
      endcase
`ifdef CLK_STRETCH_EN
      // Load point reached with nothing to send: hold SCL until tx_valid.
      if (load_pt) begin
        scl_oe_n    = 1'b1;
        load_wait_n = 1'b1;
      end
`endif
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.busy      = busy_q;
  assign bus.tx_ready  = tx_ready_q;
  assign bus.nack_seen = nack_q;
  assign bus.underrun  = underrun_q;
`ifdef CLK_STRETCH_EN
  assign bus.scl_oe    = scl_oe_q;
`else
  assign bus.scl_oe    = 1'b0;
`endif

endmodule
